// File: rtl/gf_pkg.sv
// -----------------------------------------------------------------------------
// gf_pkg
//   Shared GF(2^8) definitions for the RS-decoder datapath.
//   GF_W          symbol width
//   GF_POLY       field polynomial x^8+x^4+x^3+x^2+1
//   GFMUL_LATENCY pipeline depth of a gfmul built with REG_IN=1, REG_OUT=1
//   gf_mul_ref()  behavioural product a*b mod GF_POLY (shift-and-add)
// -----------------------------------------------------------------------------
package gf_pkg;

    localparam int unsigned GF_W          = 8;
    localparam logic [8:0]  GF_POLY       = 9'h11D;
    localparam int unsigned GFMUL_LATENCY = 2;

    function automatic logic [GF_W-1:0] gf_mul_ref(input logic [GF_W-1:0] a,
                                                   input logic [GF_W-1:0] b);
        logic [GF_W-1:0] p;
        logic [GF_W-1:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < GF_W; i++) begin
            if (b[i]) p = p ^ x;
            // multiply x by alpha, reducing on overflow out of bit 7
            x = x[GF_W-1] ? ({x[GF_W-2:0], 1'b0} ^ GF_POLY[GF_W-1:0])
                          : {x[GF_W-2:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/gfmul_arbiter_if.sv
// -----------------------------------------------------------------------------
// gfmul_arbiter_if
//   Request/response bundle between the requesters and gfmul_arbiter.
//   req_valid  per-requester operation request
//   req_ready  one-hot grant (handshake = valid & ready)
//   req_a/b    operands, requester i at [8i+7:8i]
//   rsp_valid  one-hot, single-cycle result strobe
//   rsp_data   shared product bus, qualified by rsp_valid
//   modport master = requester side, slave = arbiter side
// -----------------------------------------------------------------------------
interface gfmul_arbiter_if
    import gf_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [GF_W*NUM_REQ-1:0] req_a;
    logic [GF_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [GF_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/gfmul_arbiter_gfmul.sv
// -----------------------------------------------------------------------------
// gfmul
//   Pipelined GF(2^8) multiplier, product in_1*in_2 mod GF_POLY.
//   REG_IN/REG_OUT select an operand register and a result register;
//   latency = REG_IN + REG_OUT. Pure datapath: no reset on any register.
//   clk    rising-edge clock
//   start  operation strobe, delayed alongside the data to form done
//   in_1   operand A
//   in_2   operand B
//   out    product
//   done   start delayed by the pipeline latency
// -----------------------------------------------------------------------------
module gfmul
    import gf_pkg::*;
#(
    parameter int unsigned REG_IN  = 1,
    parameter int unsigned REG_OUT = 1
) (
    input  logic            clk,
    input  logic            start,
    input  logic [GF_W-1:0] in_1,
    input  logic [GF_W-1:0] in_2,
    output logic [GF_W-1:0] out,
    output logic            done
);

    localparam int unsigned PW  = 2*GF_W - 1;
    localparam int unsigned LAT = REG_IN + REG_OUT;

    logic [GF_W-1:0] a_q;
    logic [GF_W-1:0] b_q;
    logic [GF_W-1:0] mul;
    logic [PW-1:0]   prod;

    generate
        if (REG_IN != 0) begin : g_reg_in
            always_ff @(posedge clk) begin
                a_q <= in_1;
                b_q <= in_2;
            end
        end else begin : g_comb_in
            always_comb begin
                a_q = in_1;
                b_q = in_2;
            end
        end
    endgenerate

    // Carry-less product, then fold the high bits back from the top down.
    always_comb begin
        prod = '0;
        for (int unsigned i = 0; i < GF_W; i++) begin
            if (b_q[i]) prod = prod ^ (PW'(a_q) << i);
        end
        for (int unsigned k = PW - 1; k >= GF_W; k--) begin
            if (prod[k]) prod = prod ^ (PW'(GF_POLY) << (k - GF_W));
        end
        mul = prod[GF_W-1:0];
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk) begin
                out <= mul;
            end
        end else begin : g_comb_out
            always_comb begin
                out = mul;
            end
        end
    endgenerate

    generate
        if (LAT != 0) begin : g_done_pipe
            logic [LAT-1:0] done_sr;
            always_ff @(posedge clk) begin
                done_sr[0] <= start;
                for (int unsigned k = 1; k < LAT; k++) begin
                    done_sr[k] <= done_sr[k-1];
                end
            end
            always_comb begin
                done = done_sr[LAT-1];
            end
        end else begin : g_done_comb
            always_comb begin
                done = start;
            end
        end
    endgenerate

endmodule

// File: rtl/gfmul_arbiter.sv
// -----------------------------------------------------------------------------
// gfmul_arbiter
//   Round-robin arbiter sharing one pipelined GF(2^8) multiplier among
//   NUM_REQ requesters. One product accepted per cycle; each result is
//   returned on the shared rsp_data bus MUL_LATENCY cycles later with a
//   one-hot rsp_valid naming its requester.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous: drop in-flight results, reset the priority pointer
//   bus    gfmul_arbiter_if.slave (req_valid/ready/a/b, rsp_valid/data)
//   busy   any product in flight
// -----------------------------------------------------------------------------
module gfmul_arbiter
    import gf_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = GFMUL_LATENCY,
    parameter int unsigned REQ_W       = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    gfmul_arbiter_if.slave bus,
    output logic          busy
);

    logic [REQ_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               hs;
    logic [REQ_W-1:0]   g;
    logic [GF_W-1:0]    mul_in_1;
    logic [GF_W-1:0]    mul_in_2;
    logic [GF_W-1:0]    mul_out;
    logic               mul_done_unused;

    logic [MUL_LATENCY-1:0] tag_vld;
    logic [REQ_W-1:0]       tag_idx [MUL_LATENCY];

    // Rotate so rr_ptr sits at bit 0, keep the lowest set bit, rotate back.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                   input logic [REQ_W-1:0]   ptr);
        logic [NUM_REQ-1:0] rot;
        logic [NUM_REQ-1:0] pick;
        rot  = NUM_REQ'({v, v} >> ptr);
        pick = rot & (~rot + NUM_REQ'(1));
        return NUM_REQ'(({pick, pick} << ptr) >> NUM_REQ);
    endfunction

    always_comb begin
        grant = '0;
        if (rst_n && !flush) grant = rr_pick(bus.req_valid, rr_ptr);
    end

    always_comb begin
        hs = |grant;
        g  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g = REQ_W'(i);
        end
    end

    assign bus.req_ready = grant;

    // AND-OR operand mux; zero when nothing is granted.
    always_comb begin
        mul_in_1 = '0;
        mul_in_2 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_in_1 = bus.req_a[GF_W*i +: GF_W];
                mul_in_2 = bus.req_b[GF_W*i +: GF_W];
            end
        end
    end

    gfmul #(
        .REG_IN  (1),
        .REG_OUT (MUL_LATENCY - 1)
    ) u_gfmul (
        .clk   (clk),
        .start (1'b0),
        .in_1  (mul_in_1),
        .in_2  (mul_in_2),
        .out   (mul_out),
        .done  (mul_done_unused)
    );

    // Control state: priority pointer and tag valid bits carry the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            tag_vld <= '0;
        end else if (flush) begin
            rr_ptr  <= '0;
            tag_vld <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= (g == REQ_W'(NUM_REQ - 1)) ? '0 : g + REQ_W'(1);
            end
            tag_vld[0] <= hs;
            for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
            end
        end
    end

    // Tag indices are only meaningful under their valid bit.
    always_ff @(posedge clk) begin
        tag_idx[0] <= g;
        for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
            tag_idx[k] <= tag_idx[k-1];
        end
    end

    // A result reaching the output in the flush cycle is dropped too.
    always_comb begin
        bus.rsp_valid = '0;
        if (tag_vld[MUL_LATENCY-1] && !flush) begin
            bus.rsp_valid[tag_idx[MUL_LATENCY-1]] = 1'b1;
        end
    end

    assign bus.rsp_data = mul_out;
    assign busy         = |tag_vld;

endmodule
